dbs_r: RTL and testbench

Sequential 1026-bit by 1024-bit unsigned integer divider for the RSA decryption datapath. It computes quotient and remainder with a radix-2 restoring shift-subtract algorithm, one quotient bit per clock. It is used mainly for modular reduction, for example deriving 2^1024 mod N for Montgomery setup. Operands are captured on a start request, and the result is held with a level `done` flag until the request is withdrawn.

---
 rtl/dbs_r.sv | 150 +++++++++++++++
 tb/tb_dbs_r.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbs_r.sv
// dbs_r: 1026-bit by 1024-bit unsigned restoring divider, one quotient bit per clock.
// Latency: 1026 cycles from the capture edge to done; minimum issue period 1028 cycles.
// Backpressure: start is a level request; the result and done are held until start drops.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - synchronous active-high reset, highest priority
//   start        - operation request, sampled only in IDLE
//   dividend     - 1026-bit unsigned dividend
//   divisor      - 1024-bit unsigned divisor (zero is not special-cased)
//   outputcount  - quotient, low 1024 bits, registered
//   remainder    - remainder, registered
//   done         - result valid, registered level
module dbs_r (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1025:0] dividend,
  input  logic [1023:0] divisor,
  output logic [1023:0] outputcount,
  output logic [1023:0] remainder,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index of the final iteration: iterations are counted 0..1025.
  localparam logic [10:0] LAST_ITER = 11'd1025;

  state_t state;
  state_t state_nxt;

  // Dividend shift register; its MSB feeds the partial remainder each iteration.
  logic [1025:0] a;
  // Latched divisor.
  logic [1023:0] d;
  // Partial remainder. Only bits [1023:0] are ever shifted into the next trial
  // value, so the top bit of the architectural 1025-bit remainder is not stored.
  logic [1023:0] p;
  // Quotient shift register. Bits that shift out of the top can never reach
  // outputcount (which is the low 1024 bits), so only 1024 bits are kept.
  logic [1023:0] q;
  // Iteration counter.
  logic [10:0]   cnt;

  // One restoring step: trial value, compare, conditional subtract.
  logic [1024:0] t;
  logic          ge;
  logic [1023:0] diff;
  logic [1023:0] p_nxt;
  logic [1023:0] q_nxt;
  logic          last_iter;

  assign t    = {p, a[1025]};
  assign ge   = (t >= {1'b0, d});
  // Modulo-2^1024 subtraction is sufficient: bit 1024 of T - D would be dropped
  // by the next shift anyway, and it is zero whenever D is nonzero.
  assign diff  = t[1023:0] - d;
  assign p_nxt = ge ? diff : t[1023:0];
  assign q_nxt = {q[1022:0], ge};

  assign last_iter = (state == BUSY) && (cnt == LAST_ITER);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == LAST_ITER) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // start must be withdrawn before another operation can be captured.
        if (!start) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a           <= '0;
      d           <= '0;
      p           <= '0;
      q           <= '0;
      cnt         <= '0;
      outputcount <= '0;
      remainder   <= '0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a   <= dividend;
            d   <= divisor;
            p   <= '0;
            q   <= '0;
            cnt <= '0;
          end
        end
        BUSY: begin
          a   <= {a[1024:0], 1'b0};
          p   <= p_nxt;
          q   <= q_nxt;
          cnt <= cnt + 11'd1;
          // The result registers take the post-iteration values so the final
          // quotient bit is included without an extra cycle.
          if (last_iter) begin
            outputcount <= q_nxt;
            remainder   <= p_nxt;
            done        <= 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            done <= 1'b0;
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbs_r.sv
module tb_dbs_r;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1025:0] dividend;
  logic [1023:0] divisor;
  logic [1023:0] outputcount;
  logic [1023:0] remainder;
  logic          done;

  typedef struct packed {
    logic [1023:0] q;
    logic [1023:0] r;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  dbs_r dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .outputcount (outputcount),
    .remainder   (remainder),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive operands with start high, queue the expected result, and step over
  // the capture edge. Called only while the DUT is idle.
  task automatic launch(input logic [1025:0] dv, input logic [1023:0] ds,
                        input logic [1023:0] eq, input logic [1023:0] er);
    exp_t e;
    e.q = eq;
    e.r = er;
    sb.push_back(e);
    dividend = dv;
    divisor  = ds;
    start    = 1'b1;
    tick();
  endtask

  // Count edges until done is seen, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 1200) begin
      tick();
      cyc++;
      if (done) break;
    end
  endtask

  // Withdraw start; DONE returns to IDLE on the next edge.
  task automatic finish_op();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    tick();
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    vectors++;
    if (outputcount !== '0) begin
      miscompares++;
      $display("FAIL reset_quot: got %0h expected 0", outputcount);
    end
    vectors++;
    if (remainder !== '0) begin
      miscompares++;
      $display("FAIL reset_rem: got %0h expected 0", remainder);
    end
    reset = 1'b0;
    tick();
  endtask

  // RSA setup vector followed by the start-held / drop / re-raise handshake.
  task automatic test_handshake();
    logic [1023:0] rsa_div;
    logic [1025:0] dv;
    logic [1024:0] two_n;
    logic [1024:0] two_d;
    logic [1024:0] r_exp;
    logic [1023:0] held_q;
    logic [1023:0] held_r;
    exp_t e;
    int cyc;
    bit stable;

    rsa_div = {20'h61119, {31{32'hA5C3_96E1}}, 12'h5B7};
    dv = '0;
    dv[1024] = 1'b1;
    two_n = '0;
    two_n[1024] = 1'b1;
    two_d = {rsa_div, 1'b0};
    r_exp = two_n - two_d;
    launch(dv, rsa_div, 1024'd2, r_exp[1023:0]);
    wait_done(cyc);
    vectors++;
    if (cyc !== 1026) begin
      miscompares++;
      $display("FAIL rsa_latency: got %0d expected 1026", cyc);
    end
    e = sb.pop_front();
    vectors++;
    if (outputcount !== e.q) begin
      miscompares++;
      $display("FAIL rsa_quot: got %0h expected %0h", outputcount, e.q);
    end
    vectors++;
    if (remainder !== e.r) begin
      miscompares++;
      $display("FAIL rsa_rem: got %0h expected %0h", remainder, e.r);
    end

    // Hold start high; change the inputs too, which must have no effect.
    held_q = outputcount;
    held_r = remainder;
    stable = 1'b1;
    dividend = 1026'd77;
    divisor = 1024'd3;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (done !== 1'b1 || outputcount !== e.q || remainder !== e.r) stable = 1'b0;
    end
    vectors++;
    if (stable !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_stable: got %b expected 1 (done=%b)", stable, done);
    end

    finish_op();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_done: got %b expected 0", done);
    end
    vectors++;
    if (outputcount !== held_q || remainder !== held_r) begin
      miscompares++;
      $display("FAIL idle_retain: got q=%0h expected q=%0h", outputcount, held_q);
    end

    launch(1026'd100, 1024'd7, 1024'd14, 1024'd2);
    wait_done(cyc);
    vectors++;
    if (cyc !== 1026) begin
      miscompares++;
      $display("FAIL reraise_latency: got %0d expected 1026", cyc);
    end
    e = sb.pop_front();
    vectors++;
    if (outputcount !== e.q || remainder !== e.r) begin
      miscompares++;
      $display("FAIL reraise_result: got q=%0h r=%0h expected q=%0h r=%0h",
               outputcount, remainder, e.q, e.r);
    end
    finish_op();
  endtask

  task automatic test_small();
    logic [1025:0] dvs [4];
    logic [1023:0] dss [4];
    logic [1023:0] eqs [4];
    logic [1023:0] ers [4];
    exp_t e;
    int cyc;
    dvs[0] = 1026'd100; dss[0] = 1024'd7;  eqs[0] = 1024'd14; ers[0] = 1024'd2;
    dvs[1] = 1026'd5;   dss[1] = 1024'd1;  eqs[1] = 1024'd5;  ers[1] = 1024'd0;
    dvs[2] = 1026'd3;   dss[2] = 1024'd10; eqs[2] = 1024'd0;  ers[2] = 1024'd3;
    dvs[3] = 1026'd10;  dss[3] = 1024'd10; eqs[3] = 1024'd1;  ers[3] = 1024'd0;
    for (int i = 0; i < 4; i++) begin
      launch(dvs[i], dss[i], eqs[i], ers[i]);
      wait_done(cyc);
      e = sb.pop_front();
      vectors++;
      if (cyc !== 1026 || outputcount !== e.q || remainder !== e.r) begin
        miscompares++;
        $display("FAIL small_%0d: got lat=%0d q=%0h r=%0h expected lat=1026 q=%0h r=%0h",
                 i, cyc, outputcount, remainder, e.q, e.r);
      end
      finish_op();
    end
  endtask

  task automatic test_overflow_div0();
    logic [1025:0] dv;
    exp_t e;
    int cyc;
    dv = 1026'd9;
    dv[1025] = 1'b1;
    launch(dv, 1024'd1, 1024'd9, 1024'd0);
    wait_done(cyc);
    e = sb.pop_front();
    vectors++;
    if (outputcount !== e.q || remainder !== e.r) begin
      miscompares++;
      $display("FAIL overflow: got q=%0h r=%0h expected q=%0h r=%0h",
               outputcount, remainder, e.q, e.r);
    end
    finish_op();

    launch(1026'h1234, 1024'd0, {1024{1'b1}}, 1024'h1234);
    wait_done(cyc);
    e = sb.pop_front();
    vectors++;
    if (cyc !== 1026 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL div0_done: got lat=%0d done=%b expected lat=1026 done=1", cyc, done);
    end
    vectors++;
    if (outputcount !== e.q || remainder !== e.r) begin
      miscompares++;
      $display("FAIL div0_result: got q=%0h r=%0h expected q=%0h r=%0h",
               outputcount, remainder, e.q, e.r);
    end
    finish_op();
  endtask

  // Random wide operands issued at the minimum period.
  task automatic test_back_to_back();
    int lens [3];
    logic [1025:0] dv;
    logic [1025:0] ds_w;
    logic [1025:0] qq;
    logic [1025:0] rr;
    logic [1023:0] ds;
    exp_t e;
    int cyc;
    lens[0] = 64;
    lens[1] = 600;
    lens[2] = 1024;
    for (int i = 0; i < 3; i++) begin
      dv = '0;
      ds = '0;
      for (int k = 0; k < 1026; k++) dv[k] = 1'($urandom_range(0, 1));
      for (int k = 0; k < lens[i]; k++) ds[k] = 1'($urandom_range(0, 1));
      ds[lens[i] - 1] = 1'b1;
      ds_w = {2'b00, ds};
      qq = dv / ds_w;
      rr = dv % ds_w;
      launch(dv, ds, qq[1023:0], rr[1023:0]);
      wait_done(cyc);
      e = sb.pop_front();
      vectors++;
      if (cyc !== 1026 || outputcount !== e.q || remainder !== e.r) begin
        miscompares++;
        $display("FAIL b2b_%0d: got lat=%0d q=%0h expected lat=1026 q=%0h", i, cyc,
                 outputcount, e.q);
      end
      finish_op();
    end
  endtask

  task automatic test_midchange();
    exp_t e;
    int cyc;
    launch(1026'd1000003, 1024'd997, 1024'd1003, 1024'd12);
    repeat (300) tick();
    dividend = 1026'd55555;
    divisor = 1024'd2;
    start = 1'b0;
    tick();
    start = 1'b1;
    dividend = 1026'd8;
    tick();
    wait_done(cyc);
    vectors++;
    if (cyc + 302 !== 1026) begin
      miscompares++;
      $display("FAIL midchange_latency: got %0d expected 1026", cyc + 302);
    end
    e = sb.pop_front();
    vectors++;
    if (outputcount !== e.q || remainder !== e.r) begin
      miscompares++;
      $display("FAIL midchange_result: got q=%0h r=%0h expected q=%0h r=%0h",
               outputcount, remainder, e.q, e.r);
    end
    finish_op();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int cyc;
    launch(1026'd5, 1024'd1, 1024'd5, 1024'd0);
    repeat (499) tick();
    reset = 1'b1;
    start = 1'b0;
    tick();
    // The aborted operation produces no result.
    void'(sb.pop_front());
    vectors++;
    if (done !== 1'b0 || outputcount !== '0 || remainder !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got done=%b q=%0h r=%0h expected all zero",
               done, outputcount, remainder);
    end
    reset = 1'b0;
    repeat (1100) tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_idle: got done=%b expected 0", done);
    end
    launch(1026'd100, 1024'd7, 1024'd14, 1024'd2);
    wait_done(cyc);
    e = sb.pop_front();
    vectors++;
    if (cyc !== 1026 || outputcount !== e.q || remainder !== e.r) begin
      miscompares++;
      $display("FAIL reset_mid_restart: got lat=%0d q=%0h r=%0h expected lat=1026 q=%0h r=%0h",
               cyc, outputcount, remainder, e.q, e.r);
    end
    finish_op();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    test_reset();
    test_handshake();
    test_small();
    test_overflow_div0();
    test_back_to_back();
    test_midchange();
    test_reset_mid();
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
